decode_issue_regfile: RTL and testbench
=======================================

Name: decode_issue_regfile

Overview:
- Upstream issue stage for the combinational Decode_And_Execute datapath (rs/rt/sel in, rd out).
- Buffers incoming 3-register instructions in a small FIFO and holds a 4-entry x 4-bit register file.
- Issues one instruction per cycle: drives operands and sel to the execute stage, then writes the returned rd back into the register file.
- Forwards the in-flight result to a dependent back-to-back instruction.

Parameters:
DEPTH, 4, instruction FIFO entries (power of 2, >=2)
CNT_W, 8, width of retire counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  FIFO can accept (count < DEPTH)
in_instr  in  9  {op[8:6], dst[5:4], src1[3:2], src2[1:0]}
run  in  1  issue enable; 0 = no new issue
ex_valid  out  1  issue register holds a live instruction
ex_sel  out  3  op to execute stage
ex_rs  out  4  operand A (value of src1)
ex_rt  out  4  operand B (value of src2)
ex_rd  in  4  combinational result from execute stage
dbg_addr  in  2  register file read address
dbg_data  out  4  reg[dbg_addr], combinational
retire_cnt  out  CNT_W  instructions written back, wraps

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n). Reset is sampled only on a rising clk edge.
- Reset values:
  - FIFO empty; in_ready=1.
  - ex_valid=0; ex_sel/ex_rs/ex_rt=0.
  - Register i = i (r0=0, r1=1, r2=2, r3=3).
  - retire_cnt=0.
  - No writeback occurs on a reset edge, even if ex_valid was 1.
- Push: on an edge with in_valid && in_ready, in_instr is written at the FIFO tail.
  - in_ready depends on count only: full means not ready, even when a pop happens the same edge.
  - No bypass from input to issue register.
- At each non-reset edge, evaluated in order:
  1. Writeback: if ex_valid, reg[dst_issue] <= ex_rd and retire_cnt <= retire_cnt+1 (mod 2^CNT_W).
  2. Issue: if run && FIFO non-empty, pop the head into the issue register, set ex_valid=1, ex_sel=op. Otherwise ex_valid<=0 and ex_sel/ex_rs/ex_rt hold their previous values.
- Operand read at issue:
  - ex_rs = (ex_valid && dst_issue==src1) ? ex_rd : reg[src1].
  - Same rule for ex_rt with src2.
  - Forwarding applies to both operands independently, including src1==src2==dst_issue.
- Latency, empty FIFO and run=1:
  - Accepted at edge T.
  - ex_valid high during cycle T+1..T+2.
  - Written back at edge T+2 and visible on dbg_data after that edge.
- Throughput: 1 instruction/cycle sustained; an in-flight instruction is never stalled once issued.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- run=0: the current issued instruction still writes back; the pipe then drains to a bubble; the FIFO fills up to DEPTH.
- dbg_data reads the architectural file only (no forwarding).
- A dbg read of the register written at the same edge returns the old value before the edge and the new value after it.

Test Plan:
- Hold rst_n=0 for 2 edges -> ex_valid=0, in_ready=1, retire_cnt=0, dbg_data for addr 0..3 = 0,1,2,3.
- With the bench execute model rd=(rs+rt) mod 16 and run=1, push {op=3'b010, dst=0, src1=1, src2=2}:
  - ex_valid=1 for one cycle with ex_sel=2, ex_rs=1, ex_rt=2.
  - Afterwards r0=3 and retire_cnt=1.
- Back-to-back I1 r0=r1+r2, then I2 r1=r0+r3:
  - I2 issues with ex_rs=3 (forwarded) and ex_rt=3.
  - Final r0=3, r1=6.
- With run=0, hold in_valid for 5 instructions:
  - in_ready drops after 4 accepts; the 5th is held.
  - Raise run: 4 consecutive ex_valid cycles, then the 5th is accepted and issued; retire_cnt=5.
- Assert rst_n=0 while ex_valid=1 and the FIFO holds 3 entries:
  - Next cycle the FIFO is empty, ex_valid=0, registers are 0..3 and there is no writeback.
- Issue 256 instructions with CNT_W=8 -> retire_cnt wraps to 0; with 257 instructions -> 1.

Source files
------------

// File: rtl/decode_issue_regfile.sv
// Issue stage for the Decode_And_Execute datapath: instruction FIFO, 4x4-bit
// register file, single issue register with result forwarding and writeback.
module decode_issue_regfile #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_instr,
  input  logic             run,
  output logic             ex_valid,
  output logic [2:0]       ex_sel,
  output logic [3:0]       ex_rs,
  output logic [3:0]       ex_rt,
  input  logic [3:0]       ex_rd,
  input  logic [1:0]       dbg_addr,
  output logic [3:0]       dbg_data,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_C = DEPTH[PTR_W:0];

  logic [8:0]       fifo_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [3:0]       regs_r [4];
  logic [1:0]       dst_issue_r;

  logic       push_s;
  logic       pop_s;
  logic [8:0] head_s;
  logic [3:0] rs_s;
  logic [3:0] rt_s;

  assign in_ready = (count_r != FULL_C);
  assign dbg_data = regs_r[dbg_addr];

  // Handshakes and operand selection; the in-flight result overrides a stale register.
  always_comb begin
    push_s = in_valid && in_ready;
    pop_s  = run && (count_r != '0);
    head_s = fifo_mem_r[rd_ptr_r];
    if (ex_valid && (dst_issue_r == head_s[3:2])) begin
      rs_s = ex_rd;
    end else begin
      rs_s = regs_r[head_s[3:2]];
    end
    if (ex_valid && (dst_issue_r == head_s[1:0])) begin
      rt_s = ex_rd;
    end else begin
      rt_s = regs_r[head_s[1:0]];
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= in_instr;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Writeback of the issued instruction, then issue of the FIFO head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 4'(i);
      end
      retire_cnt  <= '0;
      ex_valid    <= 1'b0;
      ex_sel      <= 3'd0;
      ex_rs       <= 4'd0;
      ex_rt       <= 4'd0;
      dst_issue_r <= 2'd0;
    end else begin
      if (ex_valid) begin
        regs_r[dst_issue_r] <= ex_rd;
        retire_cnt          <= retire_cnt + CNT_W'(1);
      end
      if (pop_s) begin
        ex_valid    <= 1'b1;
        ex_sel      <= head_s[8:6];
        ex_rs       <= rs_s;
        ex_rt       <= rt_s;
        dst_issue_r <= head_s[5:4];
      end else begin
        ex_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_regfile.sv
// Directed bench for decode_issue_regfile with an adder as the execute stage.
module tb_decode_issue_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic       run;
  logic       ex_valid;
  logic [2:0] ex_sel;
  logic [3:0] ex_rs;
  logic [3:0] ex_rt;
  logic [3:0] ex_rd;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
  logic [7:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ex_rd = ex_rs + ex_rt;

  decode_issue_regfile #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .run(run), .ex_valid(ex_valid), .ex_sel(ex_sel),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [8:0] instr;
    logic [2:0] sel;
    logic [3:0] rs;
    logic [3:0] rt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string name, input logic [3:0] e0, input logic [3:0] e1,
                          input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("%s r%0d", name, i), {4'd0, dbg_data}, {4'd0, exp[i]});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; run = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [8:0] mk(input int op, input int dst, input int s1, input int s2);
    return {3'(op), 2'(dst), 2'(s1), 2'(s2)};
  endfunction

  initial begin
    in_instr = 9'd0;
    dbg_addr = 2'd0;

    // Hand-computed chain: adds with forwarding, registers start at 0,1,2,3.
    vecs[0] = '{mk(2, 0, 1, 2), 3'd2, 4'd1,  4'd2};   // r0=3
    vecs[1] = '{mk(5, 1, 0, 3), 3'd5, 4'd3,  4'd3};   // r1=6 (rs forwarded)
    vecs[2] = '{mk(1, 1, 1, 1), 3'd1, 4'd6,  4'd6};   // r1=12 (both forwarded)
    vecs[3] = '{mk(7, 2, 1, 0), 3'd7, 4'd12, 4'd3};   // r2=15
    vecs[4] = '{mk(0, 3, 2, 3), 3'd0, 4'd15, 4'd3};   // r3=2
    vecs[5] = '{mk(4, 0, 3, 2), 3'd4, 4'd2,  4'd15};  // r0=1
    vecs[6] = '{mk(3, 2, 0, 1), 3'd3, 4'd1,  4'd12};  // r2=13
    vecs[7] = '{mk(6, 3, 3, 3), 3'd6, 4'd2,  4'd2};   // r3=4

    // Reset state
    do_reset();
    chk("rst ex_valid", {7'd0, ex_valid}, 8'd0);
    chk("rst in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst retire_cnt", retire_cnt, 8'd0);
    chk("rst ex_sel", {5'd0, ex_sel}, 8'd0);
    chk("rst ex_rs", {4'd0, ex_rs}, 8'd0);
    chk("rst ex_rt", {4'd0, ex_rt}, 8'd0);
    chk_regs("rst", 4'd0, 4'd1, 4'd2, 4'd3);

    // Single instruction latency
    run = 1'b1;
    in_valid = 1'b1; in_instr = mk(2, 0, 1, 2);
    tick();
    in_valid = 1'b0;
    chk("lat T ex_valid", {7'd0, ex_valid}, 8'd0);
    tick();
    chk("lat T1 ex_valid", {7'd0, ex_valid}, 8'd1);
    chk("lat T1 ex_sel", {5'd0, ex_sel}, 8'd2);
    chk("lat T1 ex_rs", {4'd0, ex_rs}, 8'd1);
    chk("lat T1 ex_rt", {4'd0, ex_rt}, 8'd2);
    chk_regs("lat T1", 4'd0, 4'd1, 4'd2, 4'd3);
    tick();
    chk("lat T2 ex_valid", {7'd0, ex_valid}, 8'd0);
    chk("lat T2 retire", retire_cnt, 8'd1);
    chk_regs("lat T2", 4'd3, 4'd1, 4'd2, 4'd3);

    // Back-to-back table with forwarding
    do_reset();
    run = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      if (k < 8) in_instr = vecs[k].instr;
      tick();
      if (k > 0) begin
        chk($sformatf("vec%0d ex_valid", k-1), {7'd0, ex_valid}, 8'd1);
        chk($sformatf("vec%0d ex_sel", k-1), {5'd0, ex_sel}, {5'd0, vecs[k-1].sel});
        chk($sformatf("vec%0d ex_rs", k-1), {4'd0, ex_rs}, {4'd0, vecs[k-1].rs});
        chk($sformatf("vec%0d ex_rt", k-1), {4'd0, ex_rt}, {4'd0, vecs[k-1].rt});
      end
    end
    tick();
    chk("chain drain ex_valid", {7'd0, ex_valid}, 8'd0);
    chk("chain retire", retire_cnt, 8'd8);
    chk_regs("chain", 4'd1, 4'd12, 4'd13, 4'd4);

    // run=0 fills the FIFO; 5th instruction is held until space frees
    do_reset();
    run = 1'b0;
    in_valid = 1'b1; in_instr = mk(2, 0, 1, 2);
    for (int i = 0; i < 4; i++) tick();
    chk("fill in_ready", {7'd0, in_ready}, 8'd0);
    tick();
    tick();
    chk("held in_ready", {7'd0, in_ready}, 8'd0);
    chk("held ex_valid", {7'd0, ex_valid}, 8'd0);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("drain%0d ex_valid", i), {7'd0, ex_valid}, 8'd1);
      if (i == 1) in_valid = 1'b0;
    end
    tick();
    chk("drain end ex_valid", {7'd0, ex_valid}, 8'd0);
    chk("drain retire", retire_cnt, 8'd5);
    chk("drain in_ready", {7'd0, in_ready}, 8'd1);

    // Reset while an instruction is in flight and 3 entries are queued
    do_reset();
    run = 1'b0;
    in_valid = 1'b1; in_instr = mk(2, 0, 1, 2);
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    run = 1'b1;
    tick();
    chk("pre-rst ex_valid", {7'd0, ex_valid}, 8'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst ex_valid", {7'd0, ex_valid}, 8'd0);
    chk("midrst in_ready", {7'd0, in_ready}, 8'd1);
    chk("midrst retire", retire_cnt, 8'd0);
    chk_regs("midrst", 4'd0, 4'd1, 4'd2, 4'd3);
    tick();
    chk("post-rst empty ex_valid", {7'd0, ex_valid}, 8'd0);

    // Retire counter wrap
    do_reset();
    run = 1'b1;
    in_valid = 1'b1; in_instr = mk(1, 3, 0, 1);
    for (int i = 0; i < 256; i++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("wrap256 ex_valid", {7'd0, ex_valid}, 8'd0);
    chk("wrap256 retire", retire_cnt, 8'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("wrap257 retire", retire_cnt, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
